dot_product_sequencer: RTL and testbench
========================================

# dot_product_sequencer

Controller that computes one dot product of up to KMAX elements on the shared LEN-lane adder pyramid. For each vector it issues chunk requests to the operand/multiplier stage, masks the lanes past the vector end, and accumulates the pyramid sum of every returned chunk. The final sum is held for a valid/ready consumer. It sits between the matrix-multiply top-level scheduler (start/length) and the multiplier array plus pyramid adder datapath.

## Interface
- N, 32, accumulator and sum width in bits
- LEN, 4, pyramid lanes, i.e. elements per chunk (≥1)
- KMAX, 64, maximum vector length in elements (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a new dot product; sampled only in IDLE
- k_len  in  $clog2(KMAX+1)  vector length in elements, sampled with start
- busy  out  1  high in any state other than IDLE
- chunk_req  out  1  request for the chunk at chunk_addr
- chunk_addr  out  $clog2(ceil(KMAX/LEN))  (min 1)  chunk index
- lane_mask  out  LEN  lane i enabled iff chunk_addr*LEN+i < k_len; the datapath zeroes disabled lanes before the pyramid
- chunk_valid  in  1  returned chunk present; its pyramid sum is on sum_in this cycle
- sum_in  in  N  combinational pyramid result for the returned chunk
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  N  accumulated dot product

## Operation
- States: IDLE, FETCH, OUT.
- IDLE: when start=1, latch k_len. Values above KMAX are saturated to KMAX. Clear the accumulator.
  - If the latched length is 0, go to OUT with result 0.
  - Otherwise set chunk_addr=0 and go to FETCH.
  - start=0 leaves the block in IDLE.
- FETCH: chunk_req=1, with chunk_addr and lane_mask stable until chunk_valid.
  - On chunk_valid=1, set acc ← acc + sum_in (modulo 2^N, wrap, no saturation).
  - If chunk_addr is the last chunk, ceil(len/LEN)−1, go to OUT. Otherwise increment chunk_addr and stay in FETCH, so chunk_req remains high.
  - One chunk is outstanding at most. chunk_valid may arrive in the same cycle that chunk_req first rises.
- OUT: out_valid=1, result=acc held stable.
  - On out_ready=1, go to IDLE.
  - A start in the acceptance cycle is ignored; it must be re-presented in IDLE.
- chunk_valid outside FETCH is ignored.
- start outside IDLE is ignored, and k_len changes have no effect after latching.
- lane_mask is all-ones for full chunks. For the last chunk it has (len mod LEN) low bits set when len mod LEN ≠ 0. It is 0 outside FETCH.
- result is updated only from the accumulator and is 0 outside OUT.

## Timing
- Reset (asynchronous, any state, including mid-vector): state=IDLE; busy, chunk_req, chunk_addr, lane_mask, out_valid, result all 0; accumulator 0. The in-flight chunk is abandoned, and a later chunk_valid is ignored.
- Cycle numbering: start is sampled at edge 0, so the block is in FETCH from cycle 1 with chunk_addr=0.
- With chunk_valid tied high, chunk c is accumulated at edge c+1. For C=ceil(len/LEN) chunks, out_valid rises in cycle C+1.
- Each cycle of chunk_valid=0 in FETCH adds one cycle of latency.
- len=0: out_valid in cycle 1.
- OUT with out_ready=1 on arrival: one cycle in OUT, IDLE the next cycle. The minimum start-to-start period is C+2 cycles.
- busy is a registered state decode. It is high from cycle 1 through the last OUT cycle.

## Test plan
- Reset mid-operation: k_len=8; assert reset while in FETCH at chunk 1 → all outputs 0 in the same cycle. Then k_len=4, start, sum_in=7 → result=7.
- Basic: LEN=4, k_len=8, chunk_valid=1 always, sum_in=10 then 20 → chunk_addr 0 then 1, lane_mask=1111 both cycles, out_valid in cycle 3, result=30.
- Partial chunk and stalls: k_len=6, chunk_valid delayed 3 cycles per chunk, sum_in=5 then 9 → chunk_req held and chunk_addr stable while stalled, lane_mask=1111 then 0011, result=14.
- Zero and saturation:
  - k_len=0 → out_valid in cycle 1, result=0, chunk_req never asserted.
  - k_len=65 with KMAX=64 → exactly 16 chunks requested.
- Backpressure and ignored inputs: out_ready=0 for 5 cycles → result and out_valid stable, with start and chunk_valid pulses ignored. Then out_ready=1 → IDLE next cycle.
- Wrap: N=8, k_len=8, sum_in=200 then 100 → result=44.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: walks a vector in LEN-element chunks, masks the tail lanes,
// accumulates each returned pyramid sum and holds the result for a valid/ready consumer.
module dot_product_sequencer #(
  parameter int unsigned N    = 32,
  parameter int unsigned LEN  = 4,
  parameter int unsigned KMAX = 64,
  localparam int unsigned KW     = $clog2(KMAX + 1),
  localparam int unsigned CHUNKS = (KMAX + LEN - 1) / LEN,
  localparam int unsigned AW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  output logic           busy,
  output logic           chunk_req,
  output logic [AW-1:0]  chunk_addr,
  output logic [LEN-1:0] lane_mask,
  input  logic           chunk_valid,
  input  logic [N-1:0]   sum_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t         state;
  logic [KW-1:0]  len_q;
  logic [KW-1:0]  len_sat;
  logic [AW-1:0]  last_addr;
  logic [AW-1:0]  first_last;
  logic [AW-1:0]  addr_next;
  logic [LEN-1:0] mask_first;
  logic [LEN-1:0] mask_next;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_sum;

  // Lane i of chunk addr carries element addr*LEN+i; it is live only below len.
  function automatic logic [LEN-1:0] mask_for(input logic [AW-1:0] addr,
                                              input logic [KW-1:0] len);
    logic [LEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LEN; i++)
      m[i] = ((32'(addr) * LEN + i) < 32'(len));
    return m;
  endfunction

  always_comb begin
    len_sat    = (32'(k_len) > KMAX) ? KW'(KMAX) : k_len;
    first_last = (len_sat == '0) ? '0 : AW'((32'(len_sat) - 1) / LEN);
    mask_first = mask_for('0, len_sat);
    addr_next  = chunk_addr + 1'b1;
    mask_next  = mask_for(addr_next, len_q);
    acc_sum    = acc + sum_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      last_addr  <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      chunk_req  <= 1'b0;
      chunk_addr <= '0;
      lane_mask  <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= len_sat;
            acc        <= '0;
            busy       <= 1'b1;
            chunk_addr <= '0;
            if (len_sat == '0) begin
              state     <= OUT;
              out_valid <= 1'b1;
              result    <= '0;
            end else begin
              state     <= FETCH;
              chunk_req <= 1'b1;
              lane_mask <= mask_first;
              last_addr <= first_last;
            end
          end
        end
        FETCH: begin
          if (chunk_valid) begin
            acc <= acc_sum;
            // The final sum goes straight to result so OUT is entered with it valid.
            if (chunk_addr == last_addr) begin
              state      <= OUT;
              chunk_req  <= 1'b0;
              lane_mask  <= '0;
              chunk_addr <= '0;
              out_valid  <= 1'b1;
              result     <= acc_sum;
            end else begin
              chunk_addr <= addr_next;
              lane_mask  <= mask_next;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Scoreboard bench for dot_product_sequencer: stimulus queues expected chunks and results,
// monitors pop and compare on each chunk acceptance and each result handshake.
module tb_dot_product_sequencer;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  k_len;
  logic        busy;
  logic        chunk_req;
  logic [3:0]  chunk_addr;
  logic [3:0]  lane_mask;
  logic        chunk_valid;
  logic [31:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  // Narrow-accumulator instance for the wrap case.
  logic        start2;
  logic [6:0]  k_len2;
  logic        busy2;
  logic        chunk_req2;
  logic [3:0]  chunk_addr2;
  logic [3:0]  lane_mask2;
  logic        chunk_valid2;
  logic [7:0]  sum_in2;
  logic        out_valid2;
  logic [7:0]  result2;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] mask;
  } chunk_t;

  chunk_t      exp_chunks[$];
  logic [31:0] exp_res[$];
  logic [7:0]  exp_res2[$];
  logic [31:0] sum_tab[16];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned stall = 0;
  int unsigned wcnt = 0;
  int unsigned chunks_acc = 0;
  bit          force_cv = 1'b0;
  bit          req_seen = 1'b0;

  dot_product_sequencer #(.N(32), .LEN(4), .KMAX(64)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
    .chunk_req(chunk_req), .chunk_addr(chunk_addr), .lane_mask(lane_mask),
    .chunk_valid(chunk_valid), .sum_in(sum_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  dot_product_sequencer #(.N(8), .LEN(4), .KMAX(64)) dut8 (
    .clk(clk), .reset(reset), .start(start2), .k_len(k_len2), .busy(busy2),
    .chunk_req(chunk_req2), .chunk_addr(chunk_addr2), .lane_mask(lane_mask2),
    .chunk_valid(chunk_valid2), .sum_in(sum_in2), .out_valid(out_valid2),
    .out_ready(1'b1), .result(result2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath responder: answers each request after `stall` idle cycles.
  always @(posedge clk) begin
    #2;
    if (chunk_req) begin
      if (wcnt >= stall) begin
        chunk_valid = 1'b1;
        sum_in      = sum_tab[chunk_addr];
        wcnt        = 0;
      end else begin
        chunk_valid = 1'b0;
        wcnt++;
      end
    end else begin
      chunk_valid = force_cv;
      sum_in      = JUNK;
      wcnt        = 0;
    end
  end

  // Chunk monitor.
  always @(negedge clk) begin
    if (!reset && chunk_req) begin
      req_seen = 1'b1;
      if (exp_chunks.size() == 0) begin
        check("chunk_unexpected", 64'(chunk_addr), 64'hFFFF);
      end else if (chunk_valid) begin
        chunk_t e;
        e = exp_chunks.pop_front();
        chunks_acc++;
        check("chunk_addr", 64'(chunk_addr), 64'(e.addr));
        check("lane_mask", 64'(lane_mask), 64'(e.mask));
      end else begin
        check("stall_addr", 64'(chunk_addr), 64'(exp_chunks[0].addr));
        check("stall_mask", 64'(lane_mask), 64'(exp_chunks[0].mask));
      end
    end
  end

  // Result monitors.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_res.size() == 0) check("result_unexpected", 64'(result), 64'hFFFF_FFFF_FFFF);
      else check("result", 64'(result), 64'(exp_res.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid2) begin
      if (exp_res2.size() == 0) check("result8_unexpected", 64'(result2), 64'hFFFF);
      else check("result8", 64'(result2), 64'(exp_res2.pop_front()));
    end
  end

  task automatic do_start(input logic [6:0] len);
    @(posedge clk); #1;
    k_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 7'd85;
  endtask

  // Called right after the start edge; cycle 1 is the first negedge seen.
  task automatic wait_out(input int unsigned exp_cyc, input string name);
    int unsigned cyc;
    bit seen;
    seen = 1'b0;
    for (cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 64'(seen ? cyc : 0), 64'(exp_cyc));
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check(name, 64'(idle), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_req"}, 64'(chunk_req), 64'd0);
    check({tag, "_addr"}, 64'(chunk_addr), 64'd0);
    check({tag, "_mask"}, 64'(lane_mask), 64'd0);
    check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1;
    chunk_valid = 1'b0; sum_in = JUNK;
    start2 = 1'b0; k_len2 = '0; chunk_valid2 = 1'b0; sum_in2 = '0;
    for (int i = 0; i < 16; i++) sum_tab[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Reset in the middle of a vector, then a clean rerun.
    sum_tab[0] = 32'd11; sum_tab[1] = 32'd12;
    exp_chunks.push_back('{4'd0, 4'hF});
    exp_chunks.push_back('{4'd1, 4'hF});
    do_start(7'd8);
    @(negedge clk);
    check("mid_addr0", 64'(chunk_addr), 64'd0);
    @(negedge clk);
    check("mid_addr1", 64'(chunk_addr), 64'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    exp_chunks.delete();
    exp_res.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sum_tab[0] = 32'd7;
    exp_chunks.push_back('{4'd0, 4'hF});
    exp_res.push_back(32'd7);
    do_start(7'd4);
    wait_out(2, "lat_rerun");
    wait_idle("idle_rerun");

    // Basic two full chunks with chunk_valid tied high.
    force_cv = 1'b1;
    sum_tab[0] = 32'd10; sum_tab[1] = 32'd20;
    exp_chunks.push_back('{4'd0, 4'hF});
    exp_chunks.push_back('{4'd1, 4'hF});
    exp_res.push_back(32'd30);
    do_start(7'd8);
    wait_out(3, "lat_basic");
    wait_idle("idle_basic");
    force_cv = 1'b0;

    // Partial tail chunk with three stall cycles per chunk.
    stall = 3;
    sum_tab[0] = 32'd5; sum_tab[1] = 32'd9;
    exp_chunks.push_back('{4'd0, 4'hF});
    exp_chunks.push_back('{4'd1, 4'h3});
    exp_res.push_back(32'd14);
    do_start(7'd6);
    wait_out(9, "lat_stall");
    wait_idle("idle_stall");
    stall = 0;

    // Zero length.
    req_seen = 1'b0;
    exp_res.push_back(32'd0);
    do_start(7'd0);
    wait_out(1, "lat_zero");
    wait_idle("idle_zero");
    check("zero_no_req", 64'(req_seen), 64'd0);

    // Saturation: 65 is clamped to 64 elements = 16 chunks.
    chunks_acc = 0;
    for (int i = 0; i < 16; i++) begin
      sum_tab[i] = 32'(i + 1);
      exp_chunks.push_back('{4'(i), 4'hF});
    end
    exp_res.push_back(32'd136);
    do_start(7'd65);
    wait_out(17, "lat_sat");
    wait_idle("idle_sat");
    check("sat_chunks", 64'(chunks_acc), 64'd16);

    // Backpressure with ignored start and chunk_valid pulses.
    out_ready = 1'b0;
    sum_tab[0] = 32'd3;
    exp_chunks.push_back('{4'd0, 4'hF});
    exp_res.push_back(32'd3);
    do_start(7'd4);
    wait_out(2, "lat_bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = ~start;
      k_len = 7'd8;
      force_cv = 1'b1;
      @(negedge clk);
      check("bp_ovalid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd3);
      check("bp_req", 64'(chunk_req), 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    force_cv = 1'b0;
    @(negedge clk);
    check("bp_idle_busy", 64'(busy), 64'd0);
    check("bp_idle_ovalid", 64'(out_valid), 64'd0);
    check("bp_idle_req", 64'(chunk_req), 64'd0);

    // 8-bit wrap: 200 + 100 = 300 mod 256 = 44.
    exp_res2.push_back(8'd44);
    @(posedge clk); #1;
    start2 = 1'b1; k_len2 = 7'd8;
    @(posedge clk); #1;
    start2 = 1'b0; chunk_valid2 = 1'b1; sum_in2 = 8'd200;
    @(negedge clk);
    check("wrap_mask0", 64'(lane_mask2), 64'hF);
    @(posedge clk); #1;
    sum_in2 = 8'd100;
    @(negedge clk);
    check("wrap_addr1", 64'(chunk_addr2), 64'd1);
    @(posedge clk); #1;
    chunk_valid2 = 1'b0;
    for (int i = 0; i < 50 && busy2; i++) @(negedge clk);
    check("wrap_idle", 64'(busy2), 64'd0);

    repeat (3) @(negedge clk);
    check("res_queue_empty", 64'(exp_res.size()), 64'd0);
    check("chunk_queue_empty", 64'(exp_chunks.size()), 64'd0);
    check("res8_queue_empty", 64'(exp_res2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
